// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and configuration helpers for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int unsigned MIN_CLKS_PER_BIT = 2;

  function automatic int unsigned FRAME_BITS(input int unsigned width,
                                             input int unsigned parity_en,
                                             input int unsigned stop_bits);
    return 1 + width + parity_en + stop_bits;
  endfunction

  function automatic bit cfg_ok(input int unsigned clks_per_bit,
                                input int unsigned stop_bits);
    return (clks_per_bit >= MIN_CLKS_PER_BIT) && (stop_bits == 1 || stop_bits == 2);
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between syncfifo (slave) and its drain stage (master).
interface fifo_uart_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_rd_en;

  modport master (input fifo_empty, input fifo_rdata, output fifo_rd_en);
  modport slave  (output fifo_empty, output fifo_rdata, input fifo_rd_en);
endinterface

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and ticks on the terminal count.
module baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt;

  assign bit_tick = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one byte at a time and serializes each byte as a
// UART frame: start, WIDTH data bits LSB-first, optional even parity, stop bit(s).
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  fifo_uart_tx_if.master        fifo,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           byte_count
);
  localparam int unsigned BCW = $clog2(FRAME_BITS(WIDTH, PARITY_EN, STOP_BITS));

  if (!cfg_ok(CLKS_PER_BIT, STOP_BITS)) begin : g_cfg_err
    $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2 and STOP_BITS 1 or 2");
  end

  state_t           state, state_next;
  logic [BCW-1:0]   bit_cnt;
  logic [WIDTH-1:0] shift;
  logic             parity;
  logic             bit_tick;
  logic             state_chg;
  logic             last_stop;

  // Both counters restart on every state entry so each state times itself.
  assign state_chg = (state_next != state);

  baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_chg),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      parity     <= 1'b0;
      frame_done <= 1'b0;
      byte_count <= '0;
    end else begin
      state      <= state_next;
      frame_done <= last_stop;
      if (last_stop) begin
        byte_count <= byte_count + 16'd1;
      end
      if (state_chg) begin
        bit_cnt <= '0;
      end else if (bit_tick) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == LOAD) begin
        shift  <= fifo.fifo_rdata;
        parity <= ^fifo.fifo_rdata;
      end else if (state == DATA && bit_tick) begin
        shift <= shift >> 1;
      end
    end
  end

  always_comb begin
    state_next = state;
    last_stop  = 1'b0;
    unique case (state)
      IDLE:   if (enable && !fifo.fifo_empty) state_next = FETCH;
      FETCH:  state_next = LOAD;
      LOAD:   state_next = START;
      START:  if (bit_tick) state_next = DATA;
      DATA:   if (bit_tick && bit_cnt == BCW'(WIDTH - 1))
                state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (bit_tick) state_next = STOP;
      STOP:   if (bit_tick && bit_cnt == BCW'(STOP_BITS - 1)) begin
                state_next = IDLE;
                last_stop  = 1'b1;
              end
      default: state_next = IDLE;
    endcase
  end

  // All handshake outputs decode straight from the state register.
  always_comb begin
    tx = 1'b1;
    unique case (state)
      START:   tx = 1'b0;
      DATA:    tx = shift[0];
      PARITY:  tx = parity;
      default: tx = 1'b1;
    endcase
  end

  assign fifo.fifo_rd_en = (state == FETCH);
  assign busy            = (state != IDLE);
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: two transmitters (no parity / even parity) fed by FIFO models.
module tb_fifo_uart_tx;
  logic clk;
  logic rst;
  logic en0, en1;
  logic tx0, busy0, done0;
  logic tx1, busy1, done1;
  logic [15:0] bc0, bc1;

  logic       wr0, wr1;
  logic [7:0] wd0, wd1;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int rd_cnt0 = 0, rd_err0 = 0, rd_cnt1 = 0, rd_err1 = 0;

  int n_checks = 0;
  int n_errors = 0;

  fifo_uart_tx_if #(.WIDTH(8)) f0 ();
  fifo_uart_tx_if #(.WIDTH(8)) f1 ();

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .enable(en0), .fifo(f0),
    .tx(tx0), .busy(busy0), .frame_done(done0), .byte_count(bc0)
  );

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .fifo(f1),
    .tx(tx1), .busy(busy1), .frame_done(done1), .byte_count(bc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read FIFO models: rdata valid the cycle after rd_en.
  always @(posedge clk) begin
    if (rst) begin
      q0.delete();
      f0.fifo_empty <= 1'b1;
    end else begin
      if (f0.fifo_rd_en) begin
        rd_cnt0++;
        if (f0.fifo_empty) rd_err0++;
        else f0.fifo_rdata <= q0.pop_front();
      end
      if (wr0) q0.push_back(wd0);
      f0.fifo_empty <= (q0.size() == 0);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      q1.delete();
      f1.fifo_empty <= 1'b1;
    end else begin
      if (f1.fifo_rd_en) begin
        rd_cnt1++;
        if (f1.fifo_empty) rd_err1++;
        else f1.fifo_rdata <= q1.pop_front();
      end
      if (wr1) q1.push_back(wd1);
      f1.fifo_empty <= (q1.size() == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic txv(input int sel);
    return (sel != 0) ? tx1 : tx0;
  endfunction

  function automatic logic donev(input int sel);
    return (sel != 0) ? done1 : done0;
  endfunction

  // Waits (bounded) for a start bit, samples mid-bit, leaves at the frame_done cycle.
  task automatic rx_frame(input int sel, input int nbits, output logic [10:0] bits, output int gap);
    int   cnt = 0;
    logic done_last = 1'b0;
    bits = '0;
    while (txv(sel) && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    gap = cnt;
    if (cnt >= 200) begin
      check("start_seen", 32'(txv(sel)), 0);
      return;
    end
    for (int k = 0; k < nbits * 4; k++) begin
      if (k > 0) @(negedge clk);
      if (k % 4 == 2) bits[k / 4] = txv(sel);
      if (k == nbits * 4 - 1) done_last = donev(sel);
    end
    @(negedge clk);
    check("done_early", 32'(done_last), 0);
    check("frame_done", 32'(donev(sel)), 1);
    check("start_bit", 32'(bits[0]), 0);
    check("stop_bit", 32'(bits[nbits - 1]), 1);
  endtask

  logic [7:0]  tbl [16] = '{8'h3A, 8'hC4, 8'h00, 8'hFF, 8'h81, 8'h7E, 8'h55, 8'hAA,
                             8'h12, 8'hED, 8'h01, 8'h80, 8'h96, 8'h69, 8'hF0, 8'h0F};
  logic [9:0]  exp_a5;
  logic [3:0]  acc;
  logic [10:0] bits;
  int          gap;
  int          rd_base;

  initial begin
    rst = 1'b1; en0 = 1'b0; en1 = 1'b0;
    wr0 = 1'b0; wr1 = 1'b0; wd0 = '0; wd1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 32'(tx0), 1);
    check("rst_rd_en", 32'(f0.fifo_rd_en), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_count", 32'(bc0), 0);
    rst = 1'b0;

    en0 = 1'b1;
    repeat (10) @(negedge clk);
    check("empty_no_fetch", 32'(rd_cnt0), 0);

    // Single byte 0xA5 with exact cycle timing.
    exp_a5 = {1'b1, 8'hA5, 1'b0};
    wd0 = 8'hA5; wr0 = 1'b1;
    @(negedge clk);
    wr0 = 1'b0;
    check("a5_rd_en_n0", 32'(f0.fifo_rd_en), 0);
    @(negedge clk);
    check("a5_rd_en_fetch", 32'(f0.fifo_rd_en), 1);
    check("a5_busy_fetch", 32'(busy0), 1);
    @(negedge clk);
    check("a5_rd_en_load", 32'(f0.fifo_rd_en), 0);
    @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        acc[c] = tx0;
        @(negedge clk);
      end
      check($sformatf("a5_bit%0d", b), 32'(acc), exp_a5[b] ? 32'hF : 32'h0);
    end
    check("a5_frame_done", 32'(done0), 1);
    check("a5_busy_end", 32'(busy0), 0);
    check("a5_count", 32'(bc0), 1);
    check("a5_one_pulse", 32'(rd_cnt0), 1);
    @(negedge clk);
    check("a5_done_pulse", 32'(done0), 0);

    // Full drain of 16 bytes.
    rst = 1'b1; en0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_base = rd_cnt0;
    for (int i = 0; i < 16; i++) begin
      wd0 = tbl[i]; wr0 = 1'b1;
      @(negedge clk);
    end
    wr0 = 1'b0;
    en0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_frame(0, 10, bits, gap);
      check($sformatf("drain_byte%0d", i), 32'(bits[8:1]), 32'(tbl[i]));
      if (i > 0) check($sformatf("drain_gap%0d", i), gap, 3);
    end
    check("drain_count", 32'(bc0), 16);
    check("drain_empty", 32'(f0.fifo_empty), 1);
    check("drain_pops", rd_cnt0 - rd_base, 16);

    // Enable dropped mid-frame; a byte arrives mid-frame but is not fetched.
    rd_base = rd_cnt0;
    wd0 = 8'h3C; wr0 = 1'b1;
    @(negedge clk);
    wr0 = 1'b0;
    fork
      rx_frame(0, 10, bits, gap);
      begin
        repeat (10) @(negedge clk);
        check("mid_busy", 32'(busy0), 1);
        en0 = 1'b0;
        wd0 = 8'h5A; wr0 = 1'b1;
        @(negedge clk);
        wr0 = 1'b0;
      end
    join
    check("en_drop_byte", 32'(bits[8:1]), 32'h3C);
    repeat (20) @(negedge clk);
    check("en_drop_pops", rd_cnt0 - rd_base, 1);
    check("en_drop_idle_tx", 32'(tx0), 1);
    check("en_drop_count", 32'(bc0), 17);

    // Reset during DATA aborts the frame.
    en0 = 1'b1;
    repeat (12) @(negedge clk);
    check("pre_rst_busy", 32'(busy0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_tx", 32'(tx0), 1);
    check("mid_rst_busy", 32'(busy0), 0);
    check("mid_rst_count", 32'(bc0), 0);
    check("mid_rst_rd_en", 32'(f0.fifo_rd_en), 0);
    check("mid_rst_done", 32'(done0), 0);
    rd_base = rd_cnt0;
    repeat (10) @(negedge clk);
    check("post_rst_no_fetch", rd_cnt0 - rd_base, 0);
    check("post_rst_tx", 32'(tx0), 1);

    // Counter wrap from 0xFFFF.
    force dut0.byte_count = 16'hFFFF;
    @(negedge clk);
    release dut0.byte_count;
    @(negedge clk);
    check("wrap_preload", 32'(bc0), 32'hFFFF);
    wd0 = 8'h81; wr0 = 1'b1;
    @(negedge clk);
    wr0 = 1'b0;
    rx_frame(0, 10, bits, gap);
    check("wrap_byte", 32'(bits[8:1]), 32'h81);
    check("wrap_count", 32'(bc0), 0);
    check("rd_err0", rd_err0, 0);

    // Even parity on the second transmitter: 11-bit frames.
    en1 = 1'b1;
    wd1 = 8'h07; wr1 = 1'b1;
    @(negedge clk);
    wr1 = 1'b0;
    rx_frame(1, 11, bits, gap);
    check("par07_byte", 32'(bits[8:1]), 32'h07);
    check("par07_parity", 32'(bits[9]), 1);
    wd1 = 8'h03; wr1 = 1'b1;
    @(negedge clk);
    wr1 = 1'b0;
    rx_frame(1, 11, bits, gap);
    check("par03_byte", 32'(bits[8:1]), 32'h03);
    check("par03_parity", 32'(bits[9]), 0);
    check("par_count", 32'(bc1), 2);
    check("par_busy_end", 32'(busy1), 0);
    check("rd_err1", rd_err1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
